pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Generates operand-forwarding selects for EX, load-use stalls, branch/jump flushes and PC redirect.
- Provides a global freeze for multi-cycle data-memory accesses, with timeout detection.
- Replaces all ad-hoc stall/forward logic in the CPU top; the top only obeys its outputs.

Parameters:
XLEN, 32, datapath/PC width
CNT_W, 16, width of saturating performance counters
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before error (1..2^CNT_W-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_rs1, id_rs2  in  5 each  source regs of instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  5 each  source regs of instruction in EX
ex_rd  in  5  dest of EX instruction
ex_load  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch or jump
ex_target  in  XLEN  redirect target from EX
mem_rd  in  5  dest of MEM instruction
mem_regwrite  in  1  MEM instruction writes rd
mem_load  in  1  MEM instruction is a load
mem_req  in  1  MEM stage issues dmem load/store this cycle
mem_ready  in  1  dmem completes the access this cycle
wb_rd  in  5  dest of WB instruction
wb_regwrite  in  1  WB instruction writes rd
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB writeback data
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
bubble_id_ex  out  1  load NOP into ID/EX
flush_if_id  out  1  load NOP into IF/ID
freeze  out  1  hold every pipeline register and PC, suppress regfile/dmem writes
pc_redirect  out  1  PC loads pc_target next edge
pc_target  out  XLEN  redirect address
mem_timeout  out  1  sticky error
stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1
flush_count  out  CNT_W  saturating count of redirects

Behaviour:
- Reset: state=RUN, wait counter=0, mem_timeout=0, both counters=0. All combinational outputs follow from reset state with inputs quiescent (all 0, pc_target=0).
- Register x0 is never a hazard/forward source: any compare with rd==0 is false.
- Forwarding (combinational, per operand X in {rs1,rs2}):
  - 01 if mem_regwrite && !mem_load && mem_rd==ex_rsX.
  - Else 10 if wb_regwrite && wb_rd==ex_rsX.
  - Else 00. MEM has priority over WB when both match.
- Load-use: lu = ex_load && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
  - lu asserts stall_pc, stall_if_id, bubble_id_ex for exactly one cycle; no state needed (bubble clears ex_load).
- Redirect: ex_redirect asserts pc_redirect, flush_if_id, bubble_id_ex the same cycle; pc_target=ex_target.
  - Redirect overrides lu: stall_pc=stall_if_id=0, since the dependent instruction is flushed.
- FSM states RUN, MEM_WAIT, ERROR:
  - RUN: if mem_req && !mem_ready, then freeze=1 this cycle, wait counter := 1, go MEM_WAIT.
  - MEM_WAIT: freeze=1 while !mem_ready and wait counter increments. On mem_ready, freeze=0 that cycle and go RUN with counter cleared. If counter == MEM_TIMEOUT with !mem_ready, go ERROR.
  - ERROR: freeze=1 permanently, mem_timeout=1, all other control outputs 0; exit only via rst.
- Priority each cycle: freeze > redirect > load-use.
  - While freeze=1: stall_pc, stall_if_id, bubble_id_ex, flush_if_id and pc_redirect are all 0, and fwd selects still computed. A redirect in EX during freeze is thus held in EX and acts on the first unfrozen cycle.
- Counters saturate at all-ones and do not change while freeze=1.
  - stall_cycles +1 per load-use stall cycle.
  - flush_count +1 per cycle with pc_redirect=1.
- rst asserted mid-MEM_WAIT or in ERROR: next cycle RUN with all state cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - FSM enum {RUN, MEM_WAIT, ERROR};
  - RV32I opcode constants (OP=0110011, OP_IMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111), used by the top to derive *_use_rs*, *_load and *_regwrite.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Back-to-back ADD x5 / ADD x6,x5,x5: EX has ex_rs1=ex_rs2=5, MEM has mem_rd=5, mem_regwrite=1 -> fwd_a=fwd_b=01, no stall. Same match in WB only -> fwd_a=fwd_b=10. Both MEM and WB match -> 01.
- LW x7 in EX (ex_load=1, ex_rd=7), ID reads x7 -> exactly one cycle of stall_pc=stall_if_id=bubble_id_ex=1 with stall_cycles 0->1. Next cycle the load is in WB when the consumer is in EX -> fwd=10.
- Load-use with ex_rd=0 -> no stall. Load-use coincident with ex_redirect=1, ex_target=0x40 -> pc_redirect=1, pc_target=0x40, flush_if_id=1, bubble_id_ex=1, stall_pc=0, flush_count=1.
- mem_req=1, mem_ready low 3 cycles then high -> freeze high for 3 cycles, low on the ready cycle, state back to RUN. A redirect held during the wait fires only on the first unfrozen cycle.
- MEM_TIMEOUT=4, mem_ready held low -> ERROR after the counter reaches 4; mem_timeout=1, freeze stuck at 1. Then rst=1 for one cycle -> mem_timeout=0, freeze=0, counters 0.
- Drive 2^CNT_W+5 load-use stalls -> stall_cycles saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline sequencing controller:
// forward-select codes, controller FSM states and opcode decode helpers.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // x0 is hard-wired zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  // Decode helpers for the CPU top that produces the *_use_rs*, *_load and *_regwrite inputs.
  function automatic logic opc_reads_rs1(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic logic opc_reads_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic logic opc_is_load(input logic [6:0] opc);
    return opc == OPC_LOAD;
  endfunction

  function automatic logic opc_writes_rd(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the CPU datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_load, ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic [4:0]       mem_rd;
  logic             mem_regwrite, mem_load, mem_req, mem_ready;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;

  logic [1:0]       fwd_a, fwd_b;
  logic             stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
  logic             freeze, pc_redirect;
  logic [XLEN-1:0]  pc_target;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_load, ex_redirect, ex_target,
           mem_rd, mem_regwrite, mem_load, mem_req, mem_ready,
           wb_rd, wb_regwrite,
    input  fwd_a, fwd_b, stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
           freeze, pc_redirect, pc_target, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_load, ex_redirect, ex_target,
           mem_rd, mem_regwrite, mem_load, mem_req, mem_ready,
           wb_rd, wb_regwrite,
    output fwd_a, fwd_b, stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
           freeze, pc_redirect, pc_target, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: EX forwarding, load-use stall, redirect flush,
// and a global freeze for multi-cycle dmem accesses with timeout trap.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  ctrl_state_t      state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             freeze;
  logic             load_use;
  logic             stall;
  logic             redirect;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [4:0]       ex_rs [2];

  assign ex_rs[0] = hz.ex_rs1;
  assign ex_rs[1] = hz.ex_rs2;

  // Forward selects stay live through a freeze; only the error trap forces them idle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [1:0] sel;
    always_comb begin
      sel = FWD_RF;
      if (state_reg != ERROR) begin
        if (hz.mem_regwrite && !hz.mem_load && reg_match(hz.mem_rd, ex_rs[gi])) begin
          sel = FWD_MEM;
        end else if (hz.wb_regwrite && reg_match(hz.wb_rd, ex_rs[gi])) begin
          sel = FWD_WB;
        end
      end
    end
  end

  assign hz.fwd_a = g_fwd[0].sel;
  assign hz.fwd_b = g_fwd[1].sel;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    freeze        = 1'b0;
    case (state_reg)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          freeze        = 1'b1;
          wait_cnt_next = CNT_W'(1);
          state_next    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          wait_cnt_next = '0;
          state_next    = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_reg == TIMEOUT_CNT) begin
            state_next = ERROR;
          end else begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign load_use = hz.ex_load &&
                    ((hz.id_use_rs1 && reg_match(hz.ex_rd, hz.id_rs1)) ||
                     (hz.id_use_rs2 && reg_match(hz.ex_rd, hz.id_rs2)));

  // Freeze beats redirect beats load-use; a redirect flushes the dependent instruction.
  assign redirect = !freeze && hz.ex_redirect;
  assign stall    = !freeze && !hz.ex_redirect && load_use;

  assign hz.freeze       = freeze;
  assign hz.pc_redirect  = redirect;
  assign hz.flush_if_id  = redirect;
  assign hz.stall_pc     = stall;
  assign hz.stall_if_id  = stall;
  assign hz.bubble_id_ex = redirect || stall;
  assign hz.pc_target    = hz.ex_target;
  assign hz.mem_timeout  = (state_reg == ERROR);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirect),
    .count (flush_cnt)
  );

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int XLEN        = 32;
  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .XLEN        (XLEN),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: length of the current unfinished dmem access, trap flag, event totals.
  int m_waited  = 0;
  bit m_err     = 1'b0;
  int m_stalls  = 0;
  int m_flushes = 0;
  bit e_busy, e_frz, e_redir, e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (m_err) return 2'd0;
    if (bus.mem_regwrite && !bus.mem_load && bus.mem_rd != 0 && bus.mem_rd == rs) return 2'd1;
    if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic compute_expect();
    bit lu;
    lu = bus.ex_load && bus.ex_rd != 0 &&
         ((bus.id_use_rs1 && bus.ex_rd == bus.id_rs1) || (bus.id_use_rs2 && bus.ex_rd == bus.id_rs2));
    e_busy  = (m_waited > 0) || bus.mem_req;
    e_frz   = m_err || (e_busy && !bus.mem_ready);
    e_redir = !e_frz && bus.ex_redirect;
    e_stall = !e_frz && !bus.ex_redirect && lu;
  endtask

  task automatic check_all();
    chk("fwd_a", 32'(bus.fwd_a), 32'(ref_fwd(bus.ex_rs1)));
    chk("fwd_b", 32'(bus.fwd_b), 32'(ref_fwd(bus.ex_rs2)));
    chk("freeze", 32'(bus.freeze), 32'(e_frz));
    chk("pc_redirect", 32'(bus.pc_redirect), 32'(e_redir));
    chk("flush_if_id", 32'(bus.flush_if_id), 32'(e_redir));
    chk("stall_pc", 32'(bus.stall_pc), 32'(e_stall));
    chk("stall_if_id", 32'(bus.stall_if_id), 32'(e_stall));
    chk("bubble_id_ex", 32'(bus.bubble_id_ex), 32'(e_stall || e_redir));
    chk("pc_target", bus.pc_target, bus.ex_target);
    chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_err));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
    chk("flush_count", 32'(bus.flush_count), 32'(m_flushes));
  endtask

  task automatic model_step();
    if (rst) begin
      m_waited = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_stall && m_stalls < CNT_MAX) m_stalls++;
      if (e_redir && m_flushes < CNT_MAX) m_flushes++;
      if (!m_err) begin
        if (e_busy && !bus.mem_ready) begin
          if (m_waited == MEM_TIMEOUT) m_err = 1'b1;
          else m_waited++;
        end else begin
          m_waited = 0;
        end
      end
    end
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic cycle(input bit do_check);
    @(negedge clk);
    compute_expect();
    $display("cyc %0d rst=%0b fwd=%0d/%0d stall=%0b redir=%0b frz=%0b tmo=%0b stalls=%0d flushes=%0d",
             cyc, rst, bus.fwd_a, bus.fwd_b, bus.stall_pc, bus.pc_redirect, bus.freeze,
             bus.mem_timeout, bus.stall_cycles, bus.flush_count);
    if (do_check) check_all();
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0; bus.ex_load = 0;
    bus.ex_redirect = 0; bus.ex_target = '0;
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_load = 0; bus.mem_req = 0; bus.mem_ready = 0;
    bus.wb_rd = 0; bus.wb_regwrite = 0;
  endtask

  task automatic rand_inputs();
    bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
    bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
    bus.ex_rs1 = 5'($urandom_range(0, 3)); bus.ex_rs2 = 5'($urandom_range(0, 3));
    bus.ex_rd = 5'($urandom_range(0, 3)); bus.ex_load = 1'($urandom);
    bus.ex_redirect = ($urandom_range(0, 3) == 0); bus.ex_target = $urandom();
    bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_regwrite = 1'($urandom);
    bus.mem_load = 1'($urandom); bus.mem_req = ($urandom_range(0, 7) == 0);
    bus.mem_ready = ($urandom_range(0, 3) != 0);
    bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_regwrite = 1'($urandom);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;

    // Reset state with quiet inputs.
    #1; chk("reset_freeze", 32'(bus.freeze), 0);
    chk("reset_stall_cycles", 32'(bus.stall_cycles), 0);
    cycle(1'b1);

    // ADD x5 then ADD x6,x5,x5: MEM, WB, both, and x0.
    bus.ex_rs1 = 5; bus.ex_rs2 = 5; bus.mem_rd = 5; bus.mem_regwrite = 1;
    #1; chk("fwd_mem_a", 32'(bus.fwd_a), 1); chk("fwd_mem_b", 32'(bus.fwd_b), 1);
    cycle(1'b1);
    bus.mem_regwrite = 0; bus.wb_rd = 5; bus.wb_regwrite = 1;
    #1; chk("fwd_wb_a", 32'(bus.fwd_a), 2);
    cycle(1'b1);
    bus.mem_regwrite = 1;
    #1; chk("fwd_both_b", 32'(bus.fwd_b), 1);
    cycle(1'b1);
    bus.ex_rs1 = 0; bus.mem_rd = 0; bus.wb_rd = 0;
    #1; chk("fwd_x0_a", 32'(bus.fwd_a), 0);
    cycle(1'b1);

    // LW x7 in EX, consumer of x7 in ID.
    idle();
    bus.ex_load = 1; bus.ex_rd = 7; bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    #1; chk("lu_stall_pc", 32'(bus.stall_pc), 1); chk("lu_bubble", 32'(bus.bubble_id_ex), 1);
    cycle(1'b1);
    idle();
    bus.mem_rd = 7; bus.mem_regwrite = 1; bus.mem_load = 1; bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    #1; chk("lu_one_cycle", 32'(bus.stall_pc), 0); chk("lu_count", 32'(bus.stall_cycles), 1);
    cycle(1'b1);
    idle();
    bus.ex_rs1 = 7; bus.wb_rd = 7; bus.wb_regwrite = 1;
    #1; chk("lu_fwd_wb", 32'(bus.fwd_a), 2);
    cycle(1'b1);

    // Load into x0 is never a hazard.
    idle();
    bus.ex_load = 1; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_use_rs1 = 1;
    #1; chk("lu_x0", 32'(bus.stall_pc), 0);
    cycle(1'b1);

    // Load-use coincident with a taken branch.
    bus.ex_rd = 7; bus.id_rs1 = 7; bus.ex_redirect = 1; bus.ex_target = 32'h40;
    #1; chk("redir_pc_target", bus.pc_target, 32'h40); chk("redir_stall_pc", 32'(bus.stall_pc), 0);
    chk("redir_flush", 32'(bus.flush_if_id), 1);
    cycle(1'b1);
    idle();
    #1; chk("redir_flush_count", 32'(bus.flush_count), 1);
    cycle(1'b1);

    // Three wait cycles with a redirect held in EX.
    bus.mem_req = 1; bus.mem_ready = 0; bus.ex_redirect = 1; bus.ex_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1; chk("wait_freeze", 32'(bus.freeze), 1); chk("wait_no_redir", 32'(bus.pc_redirect), 0);
      cycle(1'b1);
    end
    bus.mem_ready = 1;
    #1; chk("ready_unfreeze", 32'(bus.freeze), 0); chk("ready_redir", 32'(bus.pc_redirect), 1);
    cycle(1'b1);
    idle();
    #1; chk("wait_flush_count", 32'(bus.flush_count), 2);
    cycle(1'b1);

    // dmem never answers: trap after the timeout.
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 7; i++) cycle(1'b1);
    bus.ex_load = 1; bus.ex_rd = 3; bus.id_rs1 = 3; bus.id_use_rs1 = 1;
    bus.ex_rs1 = 4; bus.mem_rd = 4; bus.mem_regwrite = 1; bus.mem_ready = 1;
    #1; chk("err_timeout", 32'(bus.mem_timeout), 1); chk("err_freeze", 32'(bus.freeze), 1);
    chk("err_fwd_a", 32'(bus.fwd_a), 0); chk("err_stall", 32'(bus.stall_pc), 0);
    cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    idle();
    #1; chk("post_rst_timeout", 32'(bus.mem_timeout), 0); chk("post_rst_freeze", 32'(bus.freeze), 0);
    chk("post_rst_flushes", 32'(bus.flush_count), 0);
    cycle(1'b1);

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 63) == 0);
      cycle(1'b1);
    end
    rst = 1'b1; idle();
    cycle(1'b1);
    rst = 1'b0;

    // Saturation of the stall counter.
    bus.ex_load = 1; bus.ex_rd = 3; bus.id_rs2 = 3; bus.id_use_rs2 = 1;
    for (int i = 0; i < CNT_MAX + 1 + 5; i++) cycle(1'b1);
    #1; chk("stall_saturated", 32'(bus.stall_cycles), CNT_MAX);
    cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
